// File: rtl/game_timer_pkg.sv
// Shared definitions for the round timer: time-word layout, state encoding
// and the seconds/minutes increment rule.
package game_timer_pkg;

  localparam int TIME_BUS_SIZE = 12;
  localparam int SEC_MAX       = 59;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
  } game_time_t;

  function automatic game_time_t time_inc(input game_time_t t);
    game_time_t r;
    if (t.sec < 6'(SEC_MAX)) begin
      r.min = t.min;
      r.sec = t.sec + 6'd1;
    end else begin
      r.min = t.min + 6'd1;
      r.sec = 6'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_timer_tick_divider.sv
// Prescaler: counts enabled clocks 0..CLK_FREQ-1 and flags the wrap cycle.
// Holds its count whenever en is low; clear returns it to zero.
module tick_divider #(
  parameter int CLK_FREQ = 65_000_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Round play-time counter: start/pause/stop/timeout FSM over a 1 Hz prescaler,
// producing the {minutes, seconds} word and the overlay enable level.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_FREQ    = 65_000_000,
  parameter int MAX_MINUTES = 59
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  output logic [TIME_BUS_SIZE-1:0] game_time,
  output logic                     second_tick,
  output logic                     running,
  output logic                     finished
);

  localparam game_time_t TIME_LIMIT = '{min: 6'(MAX_MINUTES), sec: 6'(SEC_MAX)};

  tmr_state_e state_q, state_d;
  game_time_t time_q, time_d;
  logic       tick_q, tick_d;
  logic       presc_en, presc_tick;

  // A stop in the wrap cycle must swallow the increment, so it also gates the prescaler.
  assign presc_en = (state_q == TMR_RUN) && !pause && !stop;

  tick_divider #(
    .CLK_FREQ(CLK_FREQ)
  ) u_div (
    .pclk (pclk),
    .rst  (rst),
    .clear(start),
    .en   (presc_en),
    .tick (presc_tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tick_d  = 1'b0;
    if (start) begin
      state_d = TMR_RUN;
      time_d  = '0;
    end else if (state_q == TMR_RUN) begin
      if (stop) begin
        state_d = TMR_DONE;
      end else if (presc_tick) begin
        time_d = time_inc(time_q);
        tick_d = 1'b1;
        if (time_d == TIME_LIMIT) state_d = TMR_DONE;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      time_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
    end
  end

  assign game_time   = time_q;
  assign second_tick = tick_q;
  assign running     = (state_q == TMR_RUN);
  assign finished    = (state_q == TMR_DONE);

endmodule
